// File: rtl/bus_slave_responder_pkg.sv
// Shared types and constants for the on-chip bus slave endpoint.
// Also carries the slave window start addresses used when instantiating slots.
package bus_slave_responder_pkg;

  localparam int unsigned BusDataWidth = 32;
  localparam int unsigned BusStrbWidth = BusDataWidth / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_state_e;

  localparam logic [31:0] Slave0Start = 32'h0000_0000;
  localparam logic [31:0] Slave1Start = 32'h0000_1000;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/bus_slave_responder_regfile.sv
// Word-addressed register file behind one bus slave slot.
// Byte-enable synchronous write, combinational read, synchronous clear on reset.
module bus_slave_responder_regfile
  import bus_slave_responder_pkg::*;
#(
  parameter int unsigned DWidth   = BusDataWidth,
  parameter int unsigned NumWords = 16,
  localparam int unsigned IdxW    = $clog2(NumWords)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [IdxW-1:0]     idx_i,
  input  logic [DWidth-1:0]   wdata_i,
  input  logic [DWidth/8-1:0] be_i,
  output logic [DWidth-1:0]   rdata_o
);

  logic [DWidth-1:0] mem_q [NumWords];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int w = 0; w < NumWords; w++) mem_q[w] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < DWidth / 8; b++) begin
        if (be_i[b]) mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/bus_slave_responder.sv
// Bus slave endpoint: accepts one selected request, waits a fixed number of
// cycles, then returns a single response beat backed by a local register file.
module bus_slave_responder
  import bus_slave_responder_pkg::*;
#(
  parameter int unsigned       DWidth     = BusDataWidth,
  parameter int unsigned       NumWords   = 16,
  parameter logic [DWidth-1:0] BaseAddr   = '0,
  parameter int unsigned       WaitCycles = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                sel_i,
  input  logic                we_i,
  input  logic [DWidth-1:0]   addr_i,
  input  logic [DWidth-1:0]   wdata_i,
  input  logic [DWidth/8-1:0] be_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  output logic [DWidth-1:0]   rdata_o,
  output logic                err_o
);

  localparam int unsigned       IdxW     = $clog2(NumWords);
  localparam logic [DWidth-1:0] WinBytes = DWidth'(NumWords * 4);
  localparam logic [3:0]        WaitLoad = 4'(WaitCycles);

  bus_state_e          state_q, state_d;
  logic [3:0]          cnt_q;
  logic [DWidth-1:0]   addr_q, wdata_q;
  logic [DWidth/8-1:0] be_q;
  logic                we_q;
  logic [DWidth-1:0]   off;
  logic                addr_err;
  logic [IdxW-1:0]     idx;
  logic [DWidth-1:0]   rd_word;
  logic                accept, commit;

  assign accept = (state_q == IDLE) && req_i && sel_i && rst_ni;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = (WaitCycles == 0) ? RESP : WAIT;
      WAIT:    if (cnt_q == 4'd1) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else if (accept) begin
      cnt_q   <= WaitLoad;
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      be_q    <= be_i;
      we_q    <= we_i;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Unsigned offset: addresses below the window wrap to huge values and fail the range check.
  assign off      = addr_q - BaseAddr;
  assign addr_err = (off >= WinBytes) || !word_aligned(off[1:0]);
  assign idx      = off[IdxW+1:2];
  assign commit   = (state_q == RESP) && we_q && !addr_err && rst_ni;

  bus_slave_responder_regfile #(
    .DWidth  (DWidth),
    .NumWords(NumWords)
  ) u_regfile (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .we_i   (commit),
    .idx_i  (idx),
    .wdata_i(wdata_q),
    .be_i   (be_q),
    .rdata_o(rd_word)
  );

  always_comb begin
    gnt_o    = accept;
    rvalid_o = (state_q == RESP) && rst_ni;
    err_o    = rvalid_o && addr_err;
    rdata_o  = (rvalid_o && !we_q && !addr_err) ? rd_word : '0;
  end

endmodule

// File: tb/tb_bus_slave_responder.sv
// Self-checking bench for bus_slave_responder: directed scenarios plus random
// transactions compared against a word-array model of the slave window.
module tb_bus_slave_responder;

  localparam logic [31:0] Base = 32'h0000_1000;
  localparam int          W    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, sel, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic        req0, sel0;
  logic        gnt0, rvalid0, err0;
  logic [31:0] rdata0;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem [16];

  always #5 clk = ~clk;

  bus_slave_responder #(.DWidth(32), .NumWords(16), .BaseAddr(Base), .WaitCycles(W)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .sel_i(sel), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err)
  );

  bus_slave_responder #(.DWidth(32), .NumWords(16), .BaseAddr(Base), .WaitCycles(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .sel_i(sel0), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - Base;
    return (off >= 32'd64) || (a[1:0] != 2'b00);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - Base;
    return int'(off[5:2]);
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic txn(input string tag, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b);
    logic        e;
    logic [31:0] exp_rd;
    int          lat;
    e      = model_err(a);
    exp_rd = (!w && !e) ? mem[model_idx(a)] : 32'h0;
    req = 1'b1; sel = 1'b1; we = w; addr = a; wdata = d; be = b;
    #1;
    chk({tag, "_gnt"}, {31'b0, gnt}, 32'd1);
    @(posedge clk); #1;
    req = 1'b0; sel = 1'b0; addr = $urandom; wdata = $urandom; be = 4'($urandom);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (rvalid) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(W + 1));
    chk({tag, "_err"}, {31'b0, err}, {31'b0, e});
    chk({tag, "_rdata"}, rdata, exp_rd);
    if (w && !e) begin
      for (int k = 0; k < 4; k++) if (b[k]) mem[model_idx(a)][k*8 +: 8] = d[k*8 +: 8];
    end
    @(posedge clk); #1;
    chk({tag, "_rvalid_done"}, {31'b0, rvalid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [31:0] rq [$];
    logic [31:0] exp_rd;

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst_n = 1'b0; req = 1'b1; sel = 1'b1; we = 1'b0; addr = Base; wdata = '0; be = '0;
    req0 = 1'b1; sel0 = 1'b1;

    // Reset held with a selected request pending: nothing may be granted.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rst_gnt", {31'b0, gnt}, 32'd0);
      chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
      chk("rst_out", {rvalid, err, rdata}, 34'd0);
    end
    req = 1'b0; sel = 1'b0; req0 = 1'b0; sel0 = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_out", {gnt, rvalid, err, rdata}, 35'd0);

    // Request without select is ignored.
    req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("nosel_gnt", {31'b0, gnt}, 32'd0);
      chk("nosel_rvalid", {31'b0, rvalid}, 32'd0);
    end
    req = 1'b0;

    txn("wr_1004", 1'b1, 32'h1004, 32'hDEADBEEF, 4'hF);
    txn("rd_1004", 1'b0, 32'h1004, 32'h0, 4'h0);
    chk("rd_1004_const", mem[1], 32'hDEADBEEF);

    txn("wr_w0", 1'b1, 32'h1000, 32'h11223344, 4'hF);
    txn("wr_w0_be", 1'b1, 32'h1000, 32'hAABBCCDD, 4'b0101);
    txn("wr_w0_be0", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'b0000);
    txn("rd_w0", 1'b0, 32'h1000, 32'h0, 4'h0);
    chk("byte_merge_const", mem[0], 32'h11BB33DD);

    txn("wr_w15", 1'b1, 32'h103C, 32'h5A5A_0F0F, 4'hF);
    txn("err_rd_1040", 1'b0, 32'h1040, 32'h0, 4'h0);
    txn("err_rd_1002", 1'b0, 32'h1002, 32'h0, 4'h0);
    txn("err_wr_0ffc", 1'b1, 32'h0FFC, 32'h1234_5678, 4'hF);
    txn("rd_w15", 1'b0, 32'h103C, 32'h0, 4'h0);

    // Continuous selected requests with fresh payload every cycle.
    req = 1'b1; sel = 1'b1; we = 1'b0;
    for (int c = 0; c < 12; c++) begin
      addr = Base + (32'($urandom_range(0, 15)) << 2);
      wdata = $urandom;
      #1;
      chk("hold_gnt", {31'b0, gnt}, {31'b0, (c % 4) == 0});
      if (gnt) rq.push_back(mem[model_idx(addr)]);
      if (rvalid) begin
        exp_rd = (rq.size() > 0) ? rq.pop_front() : 32'hBAD0_BAD0;
        chk("hold_rdata", rdata, exp_rd);
      end
      @(posedge clk); #1;
    end
    req = 1'b0; sel = 1'b0;
    chk("hold_drained", 32'(rq.size()), 32'd0);

    // Reset during WAIT of a write aborts it and clears storage.
    req = 1'b1; sel = 1'b1; we = 1'b1; addr = 32'h1008; wdata = 32'hCAFE_F00D; be = 4'hF;
    #1;
    chk("abort_gnt", {31'b0, gnt}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_gnt_in_rst", {31'b0, gnt}, 32'd0);
    chk("abort_out_in_rst", {rvalid, err, rdata}, 34'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; req = 1'b0; sel = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    for (int c = 0; c < 6; c++) begin
      chk("abort_no_rvalid", {31'b0, rvalid}, 32'd0);
      @(posedge clk); #1;
    end
    txn("rd_1008_after_rst", 1'b0, 32'h1008, 32'h0, 4'h0);

    // Random traffic, occasionally out of window or misaligned.
    for (int t = 0; t < 24; t++) begin
      a = Base + (32'($urandom_range(0, 17)) << 2) + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      d = $urandom;
      txn("rand", 1'($urandom_range(0, 1)), a, d, 4'($urandom_range(0, 15)));
    end

    // Zero-wait instance: response on the cycle right after the grant.
    req0 = 1'b1; sel0 = 1'b1; we = 1'b1; addr = 32'h1004; wdata = 32'h1234_5678; be = 4'hF;
    #1;
    chk("w0_wr_gnt", {31'b0, gnt0}, 32'd1);
    chk("w0_wr_early", {31'b0, rvalid0}, 32'd0);
    @(posedge clk); #1;
    req0 = 1'b0; sel0 = 1'b0;
    chk("w0_wr_rsp", {rvalid0, err0, rdata0}, {2'b10, 32'h0});
    @(posedge clk); #1;
    chk("w0_idle", {31'b0, rvalid0}, 32'd0);
    req0 = 1'b1; sel0 = 1'b1; we = 1'b0; wdata = 32'h0;
    #1;
    chk("w0_rd_gnt", {31'b0, gnt0}, 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0; sel0 = 1'b0;
    chk("w0_rd_rsp", {rvalid0, err0, rdata0}, {2'b10, 32'h1234_5678});
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_slave_responder.md
# bus_slave_responder

Slave-side endpoint of the on-chip bus: it answers transactions the interconnect address decoder routes to one slave slot. Accepts a request qualified by its decoder select line, inserts a fixed number of wait states, then returns one response beat with read data and an error flag. Backed by a local word-addressed register file with byte-enable writes. One instance sits behind each `sel_o[k]` / `mux_sel_o == k` slot, feeding the response mux back to the master.

## Interface
- `DWidth`, 32: data and address width (bits); must be 32.
- `NumWords`, 16: register-file depth in words; power of two, ≥2.
- `BaseAddr`, 32'h0: slave window start (word-aligned); equals the matching `SlaveN_Start` in `pkg_memorymap`.
- `WaitCycles`, 2: wait states between accept and response; 0..15.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock; reset is synchronous and active-low.
- `req_i`  in  1  master request valid; held with payload until `gnt_o`.
- `sel_i`  in  1  decoder select for this slave.
- `we_i`  in  1  1 = write, 0 = read.
- `addr_i`  in  DWidth  byte address.
- `wdata_i`  in  DWidth  write data.
- `be_i`  in  DWidth/8  byte enables (writes only).
- `gnt_o`  out  1  request accepted this cycle.
- `rvalid_o`  out  1  response beat valid (one cycle).
- `rdata_o`  out  DWidth  read data; 0 when `rvalid_o`=0 or on write or error.
- `err_o`  out  1  error response; 0 when `rvalid_o`=0.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `gnt_o = req_i & sel_i` (combinational). On grant, latch `addr_i`, `we_i`, `wdata_i`, `be_i`, load the wait counter with `WaitCycles`, and go to WAIT (or to RESP if `WaitCycles`=0). `req_i` without `sel_i` is ignored.
- WAIT: the counter decrements each cycle. When it reaches 1, go to RESP. `gnt_o`=0.
- RESP: `rvalid_o`=1 for exactly one cycle, then go to IDLE. `gnt_o`=0 in RESP, so there are no back-to-back grants.
- Decode on the latched address. `off = addr - BaseAddr` (DWidth-bit unsigned; wrap-around below BaseAddr gives a huge value).
  - Error if `off >= NumWords*4` or `addr[1:0] != 0`.
  - Word index = `off[$clog2(NumWords)+1:2]`.
- Write, no error: commit in the RESP cycle, per byte where `be[b]=1`. `rdata_o`=0.
- Write with `be`=0: OKAY response, no change to storage.
- Read, no error: `rdata_o` = stored word at the index, as of the RESP cycle.
- Error: no storage change, `rdata_o`=0, `err_o`=1.

## Timing
- Accept at cycle T (`gnt_o`=1). `rvalid_o`=1 at cycle T+1+WaitCycles.
- Minimum spacing between grants is WaitCycles+2 cycles.
- Master payload changes after a grant do not affect the in-flight transaction.
- Reset (`rst_ni`=0 at a clock edge):
  - state → IDLE, counter → 0, latched fields → 0, all storage words → 0.
  - Outputs while in reset and the first cycle after: `gnt_o`=0 (forced during reset), `rvalid_o`=0, `rdata_o`=0, `err_o`=0.
- Reset in WAIT or RESP aborts the transaction: no write is committed and no `rvalid_o` is issued.

## Structure
- `pkg_bus`: `bus_state_e` (IDLE/WAIT/RESP), `BusDataWidth`=32, `BusStrbWidth`=4.
- `pkg_memorymap` supplies `BaseAddr` values per slave instance.
- Sub-module `bus_slave_regfile`: NumWords×DWidth array, synchronous byte-enable write, combinational read, synchronous reset clear.
- Top module holds the FSM, wait counter, request latch and address checker.

## Test plan
- Reset, then idle: all outputs 0; `req_i`=1 with `sel_i`=0 → no `gnt_o`, no `rvalid_o`, ever.
- WaitCycles=2, BaseAddr=0x1000. Write 0xDEADBEEF to 0x1004 with be=4'hF (grant at T, `rvalid_o` at T+3, err=0, rdata=0). Then read 0x1004 → `rvalid_o` with rdata=0xDEADBEEF, err=0.
- Byte enables: word 0 = 0x11223344. Write 0xAABBCCDD with be=4'b0101 → read returns 0x11BB33DD.
- Errors: read 0x1040 (NumWords=16), read 0x1002, and write 0x0FFC → each gives err=1, rdata=0. A follow-up read of word 15 is unchanged.
- Hold `req_i`+`sel_i` high with a new payload each cycle → grants only at T, T+4, T+8. Changing `wdata_i` during WAIT has no effect on the stored value.
- Assert reset in WAIT of a write to 0x1008 → no `rvalid_o`. Post-reset read of 0x1008 = 0. WaitCycles=0 run: grant at T, `rvalid_o` at T+1.
